// File: rtl/cby_pkg.sv
// Shared helpers for the Y-direction connection block: select width and
// track tap mapping for the ipin muxes.
package cby_pkg;

    localparam int SEL_DISCONNECT = 0;

    // One extra code beyond the mux inputs is needed for "disconnected".
    function automatic int sel_width(input int mux_size);
        return $clog2(mux_size + 1);
    endfunction

    function automatic int track_idx(input int p, input int j, input int npin, input int chan_w);
        return (p + j * npin) % chan_w;
    endfunction

endpackage

// File: rtl/cby_ipin_mux.sv
// One grid input-pin mux; sel=0 or any out-of-range code drives 0.
module cby_ipin_mux
    import cby_pkg::*;
#(
    parameter int MUX_SIZE = 2,
    parameter int SELW     = 2
) (
    input  logic [MUX_SIZE-1:0] din,
    input  logic [SELW-1:0]     sel,
    output logic                dout
);

    always_comb begin
        dout = 1'b0;
        if (sel != SELW'(SEL_DISCONNECT)) begin
            for (int k = 1; k <= MUX_SIZE; k++) begin
                if (sel == SELW'(k)) dout = din[k-1];
            end
        end
    end

endmodule

// File: rtl/cby_param_dbuf.sv
// Y-direction connection block: track pass-through plus ipin muxes whose
// configuration is shifted into a shadow chain and applied only on commit.
module cby_param_dbuf
    import cby_pkg::*;
#(
    parameter int CHAN_W = 5,
    parameter int NPIN   = 4,
    parameter int TAPS   = 1
) (
    input  logic              prog_clk,
    input  logic              pReset,
    input  logic              ccff_en,
    input  logic              ccff_head,
    input  logic              cfg_commit,
    input  logic [CHAN_W-1:0] chany_bottom_in,
    input  logic [CHAN_W-1:0] chany_top_in,
    output logic [CHAN_W-1:0] chany_top_out,
    output logic [CHAN_W-1:0] chany_bottom_out,
    output logic [NPIN-1:0]   ipin_out,
    output logic              ccff_tail,
    output logic              cfg_full,
    output logic              cfg_err
);

    localparam int MUX_SIZE = 2 * TAPS;
    localparam int SELW     = sel_width(MUX_SIZE);
    localparam int CFG_BITS = NPIN * SELW;
    localparam int CNT_W    = $clog2(CFG_BITS + 1);

    if (CFG_BITS < 2) begin : g_bad_cfg
        $error("cby_param_dbuf: CFG_BITS must be at least 2");
    end

    logic [CFG_BITS-1:0] shadow;
    logic [CFG_BITS-1:0] active;
    logic [CNT_W-1:0]    bit_cnt;
    logic                commit_ok;

    assign chany_top_out    = chany_bottom_in;
    assign chany_bottom_out = chany_top_in;
    assign ccff_tail        = shadow[CFG_BITS-1];
    assign cfg_full         = (bit_cnt == CNT_W'(CFG_BITS));
    assign commit_ok        = cfg_commit && cfg_full;

    always_ff @(posedge prog_clk or negedge pReset) begin
        if (!pReset) begin
            shadow  <= '0;
            active  <= '0;
            bit_cnt <= '0;
            cfg_err <= 1'b0;
        end else begin
            if (ccff_en) shadow <= {shadow[CFG_BITS-2:0], ccff_head};
            if (commit_ok) active <= shadow;
            if (cfg_commit && !cfg_full) cfg_err <= 1'b1;
            // A shift landing on the commit edge is the first bit of the next load.
            if (commit_ok) bit_cnt <= ccff_en ? CNT_W'(1) : '0;
            else if (ccff_en && !cfg_full) bit_cnt <= bit_cnt + 1'b1;
        end
    end

    for (genvar p = 0; p < NPIN; p++) begin : g_pin
        logic [MUX_SIZE-1:0] din;
        for (genvar j = 0; j < TAPS; j++) begin : g_tap
            assign din[2*j]   = chany_bottom_in[track_idx(p, j, NPIN, CHAN_W)];
            assign din[2*j+1] = chany_top_in[track_idx(p, j, NPIN, CHAN_W)];
        end
        cby_ipin_mux #(
            .MUX_SIZE(MUX_SIZE),
            .SELW    (SELW)
        ) u_mux (
            .din (din),
            .sel (active[p*SELW +: SELW]),
            .dout(ipin_out[p])
        );
    end

endmodule

// File: tb/tb_cby_param_dbuf.sv
// Scoreboard bench for cby_param_dbuf: a bit-level reference model predicts
// every cycle's outputs; a negedge monitor pops and compares.
module tb_cby_param_dbuf;

    localparam int CHAN_W = 5;
    localparam int NPIN   = 4;
    localparam int MUX    = 2;
    localparam int SELW   = 2;
    localparam int CFG    = 8;

    logic              prog_clk = 1'b0;
    logic              pReset;
    logic              ccff_en, ccff_head, cfg_commit;
    logic [CHAN_W-1:0] chany_bottom_in, chany_top_in;
    logic [CHAN_W-1:0] chany_top_out, chany_bottom_out;
    logic [NPIN-1:0]   ipin_out;
    logic              ccff_tail, cfg_full, cfg_err;

    always #5 prog_clk = ~prog_clk;

    cby_param_dbuf #(.CHAN_W(CHAN_W), .NPIN(NPIN), .TAPS(1)) dut (
        .prog_clk        (prog_clk),
        .pReset          (pReset),
        .ccff_en         (ccff_en),
        .ccff_head       (ccff_head),
        .cfg_commit      (cfg_commit),
        .chany_bottom_in (chany_bottom_in),
        .chany_top_in    (chany_top_in),
        .chany_top_out   (chany_top_out),
        .chany_bottom_out(chany_bottom_out),
        .ipin_out        (ipin_out),
        .ccff_tail       (ccff_tail),
        .cfg_full        (cfg_full),
        .cfg_err         (cfg_err)
    );

    typedef struct {
        logic [NPIN-1:0]   ipin;
        logic [CHAN_W-1:0] top_out;
        logic [CHAN_W-1:0] bot_out;
        logic              tail;
        logic              full;
        logic              err;
    } exp_t;

    exp_t q[$];
    int   checks = 0;
    int   errors = 0;

    // Reference state: shadow as a bit vector, count of bits loaded since last commit.
    logic [CFG-1:0] m_shadow, m_active;
    int             m_cnt;
    logic           m_err;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [NPIN-1:0] ref_ipin();
        logic [NPIN-1:0] r;
        r = '0;
        for (int p = 0; p < NPIN; p++) begin
            int sel, k, t;
            sel = int'(m_active[p*SELW +: SELW]);
            if (sel >= 1 && sel <= MUX) begin
                k = sel - 1;
                t = (p + (k / 2) * NPIN) % CHAN_W;
                r[p] = (k % 2 == 1) ? chany_top_in[t] : chany_bottom_in[t];
            end
        end
        return r;
    endfunction

    task automatic model_clear();
        m_shadow = '0;
        m_active = '0;
        m_cnt    = 0;
        m_err    = 1'b0;
    endtask

    task automatic model_edge();
        logic [CFG-1:0] pre;
        pre = m_shadow;
        if (!pReset) begin
            model_clear();
        end else begin
            if (cfg_commit) begin
                if (m_cnt == CFG) begin
                    m_active = pre;
                    m_cnt    = 0;
                end else begin
                    m_err = 1'b1;
                end
            end
            if (ccff_en) begin
                m_shadow = {pre[CFG-2:0], ccff_head};
                if (m_cnt < CFG) m_cnt++;
            end
        end
    endtask

    // Drive inputs for the next edge and predict what the DUT shows until then.
    task automatic cyc(input logic rst, input logic en, input logic head, input logic commit,
                       input logic [CHAN_W-1:0] b, input logic [CHAN_W-1:0] t);
        exp_t e;
        logic was_rst;
        @(posedge prog_clk);
        model_edge();
        #1;
        was_rst         = pReset;
        pReset          = rst;
        ccff_en         = en;
        ccff_head       = head;
        cfg_commit      = commit;
        chany_bottom_in = b;
        chany_top_in    = t;
        if (!rst) model_clear();
        if (!rst && was_rst) begin
            #1;
            chk("async_rst_ipin", 32'(ipin_out), 32'd0);
            chk("async_rst_tail", 32'(ccff_tail), 32'd0);
            chk("async_rst_full", 32'(cfg_full), 32'd0);
            chk("async_rst_err", 32'(cfg_err), 32'd0);
        end
        e.ipin    = ref_ipin();
        e.top_out = chany_bottom_in;
        e.bot_out = chany_top_in;
        e.tail    = m_shadow[CFG-1];
        e.full    = (m_cnt == CFG);
        e.err     = m_err;
        q.push_back(e);
    endtask

    task automatic idle(input logic commit);
        cyc(1'b1, 1'b0, 1'b0, commit, chany_bottom_in, chany_top_in);
    endtask

    task automatic load(input logic [CFG-1:0] v, input int n);
        for (int i = n - 1; i >= 0; i--)
            cyc(1'b1, 1'b1, v[i], 1'b0, chany_bottom_in, chany_top_in);
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge prog_clk);
            if (q.size() > 0) begin
                e = q.pop_front();
                chk("ipin_out", 32'(ipin_out), 32'(e.ipin));
                chk("chany_top_out", 32'(chany_top_out), 32'(e.top_out));
                chk("chany_bottom_out", 32'(chany_bottom_out), 32'(e.bot_out));
                chk("ccff_tail", 32'(ccff_tail), 32'(e.tail));
                chk("cfg_full", 32'(cfg_full), 32'(e.full));
                chk("cfg_err", 32'(cfg_err), 32'(e.err));
            end
        end
    end

    initial begin : driver
        int budget;
        pReset = 1'b0; ccff_en = 1'b0; ccff_head = 1'b0; cfg_commit = 1'b0;
        chany_bottom_in = '0; chany_top_in = '0;
        model_clear();

        // Reset state and pass-through under reset
        cyc(1'b0, 1'b0, 1'b0, 1'b0, 5'h1F, 5'h00);
        cyc(1'b0, 1'b0, 1'b0, 1'b0, 5'h1F, 5'h0A);
        cyc(1'b1, 1'b0, 1'b0, 1'b0, 5'h1F, 5'h15);

        // Pin 0 selects bottom track 0
        cyc(1'b1, 1'b0, 1'b0, 1'b0, 5'h01, 5'h00);
        load(8'b0000_0001, 8);
        idle(1'b1);
        idle(1'b0);
        idle(1'b0);

        // Under-filled commit is rejected and sticky
        load(8'b0100_1001, 7);
        idle(1'b1);
        idle(1'b0);
        load(8'b1001_1001, 8);
        idle(1'b1);
        cyc(1'b1, 1'b0, 1'b0, 1'b0, 5'h0F, 5'h13);
        idle(1'b0);

        // Commit with a shift in the same cycle
        load(8'b1010_0110, 8);
        cyc(1'b1, 1'b1, 1'b1, 1'b1, chany_bottom_in, chany_top_in);
        idle(1'b0);
        load(8'b0000_0011, 6);
        idle(1'b1);
        idle(1'b0);

        // Out-of-range selects always give 0
        load(8'hFF, 8);
        idle(1'b1);
        for (int i = 0; i < 6; i++)
            cyc(1'b1, 1'b0, 1'b0, 1'b0, 5'($urandom), 5'($urandom));

        // Reset asserted mid-shift
        load(8'b1111_0000, 4);
        cyc(1'b0, 1'b1, 1'b1, 1'b0, chany_bottom_in, chany_top_in);
        idle(1'b0);
        cyc(1'b1, 1'b0, 1'b0, 1'b0, chany_bottom_in, chany_top_in);

        // Random traffic with frequent complete loads
        for (int r = 0; r < 40; r++) begin
            if ($urandom_range(0, 2) != 0) begin
                load(8'($urandom), 8);
                cyc(1'b1, 1'($urandom_range(0, 1)), 1'($urandom), 1'b1,
                    5'($urandom), 5'($urandom));
            end
            for (int i = 0; i < 6; i++)
                cyc(($urandom_range(0, 60) != 0), 1'($urandom), 1'($urandom),
                    ($urandom_range(0, 7) == 0), 5'($urandom), 5'($urandom));
        end
        idle(1'b0);

        budget = 0;
        while (q.size() > 0 && budget < 20) begin
            @(posedge prog_clk);
            budget++;
        end
        @(posedge prog_clk);
        if (q.size() != 0) begin
            errors++;
            $display("FAIL drain pending=%0d expected=0", q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
